// File: rtl/common_pkg.sv
`default_nettype none
// common_pkg: types shared by the kernel launcher, its config queue and the dispatcher.
package common_pkg;

  typedef logic [31:0] data_t;

  typedef struct packed {
    data_t       kernel_addr;
    data_t       arg_addr;
    logic [15:0] num_blocks;
  } kernel_config_t;

  typedef struct packed {
    kernel_config_t cfg;
    logic [7:0]     id;
  } queue_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_RUN    = 2'd2,
    ST_REPORT = 2'd3
  } launcher_state_e;

endpackage
`default_nettype wire

// File: rtl/cfg_fifo.sv
`default_nettype none
// cfg_fifo: power-of-two depth FIFO with occupancy count; pushes when full and pops when empty are dropped.
module cfg_fifo
  import common_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  // DEPTH is a power of two, so the count MSB alone flags full.
  assign full_o  = count_q[AW];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/kernel_launcher.sv
`default_nettype none
// kernel_launcher: queues kernel launch requests and sequences CLEAR/RUN/REPORT against an external dispatcher.
// Optional run watchdog enabled by defining LAUNCHER_WATCHDOG_EN.
module kernel_launcher
  import common_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter int unsigned WDOG_LIMIT  = 65535
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          host_valid,
  output logic                          host_ready,
  input  kernel_config_t                host_config,
  output logic                          disp_reset_n,
  output logic                          disp_start,
  output kernel_config_t                disp_config,
  input  logic                          disp_finished,
  output logic                          done_valid,
  input  logic                          done_ready,
  output logic [7:0]                    done_kernel_id,
  output logic                          done_timeout,
  output logic                          busy,
  output logic [$clog2(QUEUE_DEPTH):0]  queue_count
);

  launcher_state_e state_q, state_d;
  kernel_config_t  cur_cfg_q, cur_cfg_d;
  logic [7:0]      cur_id_q, cur_id_d;
  logic [7:0]      id_ctr_q;
  logic            ready_q;
  logic            disp_reset_n_q;

  queue_entry_t    push_entry;
  queue_entry_t    head_entry;
  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic            wdog_expired;

  assign push_entry.cfg = host_config;
  assign push_entry.id  = id_ctr_q;
  // ready_q keeps host_ready low through reset and rises on the first edge after release.
  assign host_ready     = ready_q && !fifo_full;
  assign fifo_push      = host_valid && host_ready;

  cfg_fifo #(
    .WIDTH ($bits(queue_entry_t)),
    .DEPTH (QUEUE_DEPTH)
  ) u_cfg_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .data_i  (push_entry),
    .pop_i   (fifo_pop),
    .data_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (queue_count)
  );

  always_comb begin
    state_d   = state_q;
    cur_cfg_d = cur_cfg_q;
    cur_id_d  = cur_id_q;
    fifo_pop  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          cur_cfg_d = head_entry.cfg;
          cur_id_d  = head_entry.id;
          state_d   = (head_entry.cfg.num_blocks == '0) ? ST_REPORT : ST_CLEAR;
        end
      end
      ST_CLEAR: state_d = ST_RUN;
      ST_RUN: begin
        if (disp_finished || wdog_expired) state_d = ST_REPORT;
      end
      ST_REPORT: begin
        if (done_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      cur_cfg_q      <= '0;
      cur_id_q       <= '0;
      id_ctr_q       <= '0;
      ready_q        <= 1'b0;
      disp_reset_n_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cur_cfg_q      <= cur_cfg_d;
      cur_id_q       <= cur_id_d;
      ready_q        <= 1'b1;
      disp_reset_n_q <= (state_d != ST_CLEAR);
      if (fifo_push) id_ctr_q <= id_ctr_q + 8'd1;
    end
  end

`ifdef LAUNCHER_WATCHDOG_EN
  logic [31:0] wdog_q, wdog_d;
  logic        timeout_q;

  // CLEAR always precedes RUN, so clearing there gives a fresh count on RUN entry.
  always_comb begin
    wdog_d = wdog_q;
    if (state_q == ST_CLEAR)    wdog_d = '0;
    else if (state_q == ST_RUN) wdog_d = wdog_q + 32'd1;
  end

  assign wdog_expired = (state_q == ST_RUN) && ((wdog_q + 32'd1) >= WDOG_LIMIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      if (state_d == ST_REPORT && state_q != ST_REPORT)
        timeout_q <= (state_q == ST_RUN) && !disp_finished;
    end
  end

  assign done_timeout = timeout_q;
`else
  assign wdog_expired = 1'b0;
  // WDOG_LIMIT has no effect without the watchdog.
  assign done_timeout = (WDOG_LIMIT == 0) && 1'b0;
`endif

  assign disp_reset_n   = disp_reset_n_q;
  assign disp_start     = (state_q == ST_RUN);
  assign disp_config    = cur_cfg_q;
  assign done_valid     = (state_q == ST_REPORT);
  assign done_kernel_id = cur_id_q;
  assign busy           = (state_q != ST_IDLE) || !fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_kernel_launcher.sv
`default_nettype none
// tb_kernel_launcher: directed vector table, multi-cycle corner sequences and a randomized scoreboard run.
module tb_kernel_launcher;
  import common_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned WLIM  = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic           host_valid;
  logic           host_ready;
  kernel_config_t host_config;
  logic           disp_reset_n;
  logic           disp_start;
  kernel_config_t disp_config;
  logic           disp_finished;
  logic           done_valid;
  logic           done_ready;
  logic [7:0]     done_kernel_id;
  logic           done_timeout;
  logic           busy;
  logic [2:0]     queue_count;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_id  = 8'd0;

  kernel_launcher #(
    .QUEUE_DEPTH (DEPTH),
    .WDOG_LIMIT  (WLIM)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .host_valid     (host_valid),
    .host_ready     (host_ready),
    .host_config    (host_config),
    .disp_reset_n   (disp_reset_n),
    .disp_start     (disp_start),
    .disp_config    (disp_config),
    .disp_finished  (disp_finished),
    .done_valid     (done_valid),
    .done_ready     (done_ready),
    .done_kernel_id (done_kernel_id),
    .done_timeout   (done_timeout),
    .busy           (busy),
    .queue_count    (queue_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, required finish before 500000");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic kernel_config_t make_cfg(input logic [15:0] nb);
    kernel_config_t c;
    c.kernel_addr = $urandom;
    c.arg_addr    = $urandom;
    c.num_blocks  = nb;
    return c;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_host_ready"},   host_ready,     0);
    check({tag, "_disp_start"},   disp_start,     0);
    check({tag, "_disp_reset_n"}, disp_reset_n,   0);
    check({tag, "_done_valid"},   done_valid,     0);
    check({tag, "_done_timeout"}, done_timeout,   0);
    check({tag, "_done_id"},      done_kernel_id, 0);
    check({tag, "_busy"},         busy,           0);
    check({tag, "_queue_count"},  queue_count,    0);
  endtask

  // Push one kernel into an idle launcher, play the dispatcher (finish in RUN cycle index fin,
  // never if fin < 0), and measure what happened up to the report.
  task automatic run_one(input logic [15:0] nb, input int fin, output int nclr, output int nrun,
                         output int lat, output logic [7:0] id, output logic to);
    kernel_config_t cfg;
    cfg  = make_cfg(nb);
    nclr = 0;
    nrun = 0;
    host_config = cfg;
    host_valid  = 1'b1;
    step();
    host_valid = 1'b0;
    lat = 1;
    check("one_push_count", queue_count, 1);
    while (!done_valid && lat < 200) begin
      if (!disp_reset_n) nclr++;
      if (disp_start) begin
        nrun++;
        if (nrun == 1) check("one_disp_config", disp_config, cfg);
        disp_finished = ((nrun - 1) == fin);
      end else begin
        disp_finished = 1'b0;
      end
      step();
      lat++;
    end
    disp_finished = 1'b0;
    check("one_report_seen", done_valid, 1);
    id = done_kernel_id;
    to = done_timeout;
    done_ready = 1'b1;
    step();
    done_ready = 1'b0;
    exp_id++;
  endtask

  typedef struct {
    logic [15:0] nb;
    int          fin;
    int          exp_clr;
    int          exp_run;
    int          exp_lat;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int         nclr, nrun, lat, pushes, got, cyc, bad;
    logic [7:0] id, base, want;
    logic       to;

    vecs[0] = '{16'd8,      0, 1, 1, 4};
    vecs[1] = '{16'd8,      3, 1, 4, 7};
    vecs[2] = '{16'd0,      0, 0, 0, 2};
    vecs[3] = '{16'd1,      5, 1, 6, 9};
    vecs[4] = '{16'hFFFF,   1, 1, 2, 5};

    reset         = 1'b1;
    host_valid    = 1'b0;
    host_config   = '0;
    disp_finished = 1'b0;
    done_ready    = 1'b0;

    // Asynchronous reset: assert before any clock edge and look immediately.
    #2 reset = 1'b0;
    #1 check_reset_vals("rst");
    #20;
    @(negedge clk);
    reset = 1'b1;
    #1 check("ready_before_edge", host_ready, 0);
    step();
    check("ready_first_edge", host_ready, 1);
    check("disp_reset_n_idle", disp_reset_n, 1);
    check("busy_idle", busy, 0);

    for (int i = 0; i < 5; i++) begin
      want = exp_id;
      run_one(vecs[i].nb, vecs[i].fin, nclr, nrun, lat, id, to);
      check($sformatf("vec%0d_clear_cycles", i), nclr, vecs[i].exp_clr);
      check($sformatf("vec%0d_run_cycles", i),   nrun, vecs[i].exp_run);
      check($sformatf("vec%0d_latency", i),      lat,  vecs[i].exp_lat);
      check($sformatf("vec%0d_id", i),           id,   want);
      check($sformatf("vec%0d_timeout", i),      to,   0);
    end

`ifdef LAUNCHER_WATCHDOG_EN
    run_one(16'd4, -1, nclr, nrun, lat, id, to);
    check("wdog_expire_run_cycles", nrun, WLIM);
    check("wdog_expire_timeout", to, 1);
    run_one(16'd4, WLIM - 1, nclr, nrun, lat, id, to);
    check("wdog_finish_run_cycles", nrun, WLIM);
    check("wdog_finish_timeout", to, 0);
`endif

    // Five back-to-back pushes with the first report held off.
    base          = exp_id;
    pushes        = 0;
    disp_finished = 1'b1;
    host_valid    = 1'b1;
    for (int c = 0; c < 5; c++) begin
      host_config = make_cfg(16'd2);
      if (host_ready) pushes++;
      step();
    end
    exp_id = exp_id + 8'(pushes);
    check("b2b_pushes", pushes, 5);
    check("b2b_ready_low", host_ready, 0);
    check("b2b_count_full", queue_count, 4);
    check("b2b_report_valid", done_valid, 1);
    check("b2b_report_id", done_kernel_id, base);
    for (int c = 0; c < 10; c++) begin
      host_config = make_cfg(16'd2);
      step();
      check("hold_valid", done_valid, 1);
      check("hold_id", done_kernel_id, base);
      check("hold_start", disp_start, 0);
      check("hold_count", queue_count, 4);
    end
    host_valid = 1'b0;
    done_ready = 1'b1;
    got = 0;
    cyc = 0;
    while (got < 5 && cyc < 200) begin
      if (done_valid) begin
        want = base + 8'(got);
        check("b2b_order_id", done_kernel_id, want);
        got++;
      end
      step();
      cyc++;
    end
    done_ready    = 1'b0;
    disp_finished = 1'b0;
    check("b2b_reports", got, 5);
    check("b2b_drained_busy", busy, 0);

    // Reset while a kernel runs with two more queued.
    host_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      host_config = make_cfg(16'd5);
      step();
    end
    host_valid = 1'b0;
    check("midrun_in_run", disp_start, 1);
    check("midrun_queued", queue_count, 2);
    #2 reset = 1'b0;
    #1 check_reset_vals("midrun");
    @(negedge clk);
    @(negedge clk);
    reset  = 1'b1;
    exp_id = 8'd0;
    bad    = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (done_valid || disp_start) bad++;
    end
    check("midrun_no_report", bad, 0);
    check("midrun_queue_empty", queue_count, 0);

    // Randomized traffic against a FIFO scoreboard of unreported kernels.
    begin
      kernel_config_t q_cfg[$];
      logic [7:0]     q_id[$];
      kernel_config_t c;
      int             total, pushed, reported, runleft;
      logic           started;
      total    = 40;
      pushed   = 0;
      reported = 0;
      runleft  = 0;
      started  = 1'b0;
      cyc      = 0;
      while (reported < total && cyc < 20000) begin
        check("rnd_ready_vs_count", host_ready, (queue_count < 3'(DEPTH)));
        if (disp_start) begin
          if (!started) begin
            started = 1'b1;
            runleft = $urandom_range(0, 4);
            if (q_cfg.size() == 0) check("rnd_start_without_kernel", 1, 0);
            else begin
              check("rnd_disp_config", disp_config, q_cfg[0]);
              check("rnd_nonzero_blocks", (q_cfg[0].num_blocks != 0), 1);
            end
          end
          disp_finished = (runleft == 0);
          if (runleft > 0) runleft--;
        end else begin
          disp_finished = ($urandom_range(0, 3) == 0);
        end
        done_ready = ($urandom_range(0, 2) != 0);
        if (done_valid && done_ready) begin
          if (q_cfg.size() == 0) check("rnd_report_without_kernel", 1, 0);
          else begin
            check("rnd_report_id", done_kernel_id, q_id[0]);
            check("rnd_report_timeout", done_timeout, 0);
            check("rnd_ran_iff_blocks", started, (q_cfg[0].num_blocks != 0));
            void'(q_cfg.pop_front());
            void'(q_id.pop_front());
          end
          started = 1'b0;
          reported++;
        end
        host_valid = (pushed < total) && ($urandom_range(0, 3) != 0);
        if (host_valid) begin
          c = make_cfg(($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 300)));
          host_config = c;
          if (host_ready) begin
            q_cfg.push_back(c);
            q_id.push_back(exp_id);
            exp_id++;
            pushed++;
          end
        end
        step();
        cyc++;
      end
      host_valid    = 1'b0;
      done_ready    = 1'b0;
      disp_finished = 1'b0;
      check("rnd_all_reported", reported, total);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
